// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first, 8-bit frames). The
// external sclk/cs_n/mosi are oversampled in the clk domain, bytes are
// shifted in and out, and the CPU side sees a one-byte TX holding buffer
// and a one-byte RX buffer with sticky overrun/underrun flags.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   tx_data/tx_load byte to send next; load accepted while tx_ready=1
//   tx_ready        TX holding buffer empty
//   rx_data         last complete received byte
//   rx_valid/rx_ack unread-byte flag and its 1-clk clear strobe
//   status_clr      clears overrun and underrun
//   overrun         a byte completed while rx_valid was still set
//   underrun        IDLE_BYTE was sent because the TX buffer was empty
//   busy            frame in progress
//   sclk, cs_n,mosi SPI inputs from the master (asynchronous)
//   miso, miso_oe   SPI data to the master and its output enable
module spi_slave_ctrl #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic       status_clr,
  output logic       overrun,
  output logic       underrun,
  output logic       busy,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state;
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       cs_s1, cs_s2, cs_s3;
  logic       mosi_s1, mosi_s2;
  logic [7:0] tx_buf;
  logic [7:0] sh_tx;
  logic [7:0] sh_rx;
  logic [2:0] bcnt;

  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic       frame_start, boundary, consume_tx, byte_done;
  logic [7:0] rx_next;
  logic [7:0] tx_next;

  // Two-flop synchronizers; the third sclk/cs_n stage is only for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;

  // A cs_n rise ends the frame and takes priority over any sclk edge seen
  // in the same clk, so a trailing edge cannot consume the TX buffer.
  assign frame_start = (state == IDLE) && cs_fall;
  assign boundary    = (state == SHIFT) && !cs_rise && sclk_fall && (bcnt == 3'd0);
  assign consume_tx  = frame_start || boundary;
  assign byte_done   = (state == SHIFT) && !cs_rise && sclk_rise && (bcnt == 3'd7);
  assign rx_next     = {sh_rx[6:0], mosi_s2};
  assign tx_next     = tx_ready ? IDLE_BYTE : tx_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_buf   <= 8'h00;
      tx_ready <= 1'b1;
      sh_tx    <= 8'h00;
      sh_rx    <= 8'h00;
      bcnt     <= 3'd0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // The buffer is consumed before a same-clk load is accepted, so a load
      // arriving exactly at consumption refills the now-empty buffer.
      if (consume_tx && !tx_ready) begin
        tx_ready <= 1'b1;
      end
      if (tx_load && (tx_ready || consume_tx)) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end

      // Clear first so a coincident event leaves the flag set.
      if (status_clr) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
      end
      if (consume_tx && tx_ready) begin
        underrun <= 1'b1;
      end

      if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (byte_done) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            sh_tx <= tx_next;
            bcnt  <= 3'd0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            bcnt  <= 3'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (sclk_rise) begin
              sh_rx <= rx_next;
              bcnt  <= bcnt + 3'd1;
            end
            // bcnt==0 on a falling edge means the previous byte just
            // completed, so the next byte's MSB must be presented now.
            if (sclk_fall) begin
              if (bcnt == 3'd0) begin
                sh_tx <= tx_next;
              end else begin
                sh_tx <= {sh_tx[6:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miso    = busy & sh_tx[7];
  assign miso_oe = busy;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl
// Directed bench for spi_slave_ctrl. A behavioural SPI master drives
// sclk/cs_n/mosi; expected received bytes and expected miso bytes are
// queued when a transfer is set up and compared when the DUT delivers them.
module tb_spi_slave_ctrl;

  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       status_clr = 1'b0;
  logic       overrun;
  logic       underrun;
  logic       busy;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;

  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  int         last_rise_cyc = 0;
  logic       ur_before_fall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];

  spi_slave_ctrl #(.IDLE_BYTE(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .status_clr (status_clr),
    .overrun    (overrun),
    .underrun   (underrun),
    .busy       (busy),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) begin
      passes = passes + 1;
    end else begin
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master shifts nbits of out_b MSB first; miso is sampled just before
  // each rising edge, where a mode-0 master samples it.
  task automatic applyStimulus(input logic [7:0] out_b, input int nbits,
                               output logic [7:0] in_b);
    in_b = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = out_b[i];
      wait_clks(HP);
      in_b[i] = miso;
      sclk = 1'b1;
      last_rise_cyc = cyc;
      wait_clks(HP);
      ur_before_fall = underrun;
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] out_b, input string tag);
    logic [7:0] got;
    logic [7:0] exp_b;
    applyStimulus(out_b, 8, got);
    exp_b = (miso_q.size() != 0) ? miso_q.pop_front() : 8'hxx;
    checkOutput({tag, "_miso"}, 32'(got), 32'(exp_b));
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    wait_clks(4);
  endtask

  task automatic frame_end();
    wait_clks(HP);
    cs_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic pulse_load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    wait_clks(1);
    rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    wait_clks(1);
    status_clr = 1'b0;
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_tx_ready"}, 32'(tx_ready), 32'd1);
    checkOutput({pfx, "_rx_data"},  32'(rx_data),  32'd0);
    checkOutput({pfx, "_rx_valid"}, 32'(rx_valid), 32'd0);
    checkOutput({pfx, "_overrun"},  32'(overrun),  32'd0);
    checkOutput({pfx, "_underrun"}, 32'(underrun), 32'd0);
    checkOutput({pfx, "_busy"},     32'(busy),     32'd0);
    checkOutput({pfx, "_miso"},     32'(miso),     32'd0);
    checkOutput({pfx, "_miso_oe"},  32'(miso_oe),  32'd0);
  endtask

  // Each new rx_valid pops the next expected byte and checks the delay from
  // the 8th sclk rise at the pin.
  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      if (rx_q.size() == 0) begin
        checkOutput("rx_unexpected_valid", 32'(rx_valid), 32'd0);
      end else begin
        checkOutput("rx_data_sb", 32'(rx_data), 32'(rx_q.pop_front()));
        checkOutput("rx_latency_le4", 32'((cyc - last_rise_cyc) <= 4), 32'd1);
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    logic [7:0] got;

    wait_clks(3);
    checkResetValues("reset");
    rst = 1'b0;
    wait_clks(2);

    // 1: loaded byte A5 goes out while 3C comes in
    pulse_load(8'hA5);
    checkOutput("t1_tx_ready_loaded", 32'(tx_ready), 32'd0);
    miso_q.push_back(8'hA5);
    rx_q.push_back(8'h3C);
    frame_begin();
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_miso_oe", 32'(miso_oe), 32'd1);
    checkOutput("t1_tx_ready_consumed", 32'(tx_ready), 32'd1);
    xfer(8'h3C, "t1");
    checkOutput("t1_underrun_in_byte", 32'(ur_before_fall), 32'd0);
    frame_end();
    checkOutput("t1_rx_data", 32'(rx_data), 32'h3C);
    checkOutput("t1_rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    checkOutput("t1_miso_end", 32'(miso), 32'd0);
    // the trailing falling edge is a byte boundary with an empty buffer
    checkOutput("t1_underrun_trailing", 32'(underrun), 32'd1);
    pulse_ack();
    checkOutput("t1_rx_valid_acked", 32'(rx_valid), 32'd0);
    pulse_clr();
    checkOutput("t1_underrun_clr", 32'(underrun), 32'd0);

    // 2: empty TX buffer sends IDLE_BYTE
    miso_q.push_back(8'hFF);
    rx_q.push_back(8'h00);
    frame_begin();
    checkOutput("t2_underrun_set", 32'(underrun), 32'd1);
    xfer(8'h00, "t2");
    frame_end();
    pulse_ack();
    pulse_clr();
    checkOutput("t2_underrun_clr", 32'(underrun), 32'd0);

    // 3: back-to-back bytes without ack overrun, then with ack in between
    rx_q.push_back(8'h11);
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'hFF);
    frame_begin();
    xfer(8'h11, "t3a_b0");
    xfer(8'h22, "t3a_b1");
    frame_end();
    checkOutput("t3a_rx_data_kept", 32'(rx_data), 32'h11);
    checkOutput("t3a_overrun", 32'(overrun), 32'd1);
    checkOutput("t3a_rx_valid", 32'(rx_valid), 32'd1);
    pulse_ack();
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'hFF);
    frame_begin();
    xfer(8'h11, "t3b_b0");
    pulse_ack();
    xfer(8'h22, "t3b_b1");
    frame_end();
    checkOutput("t3b_rx_data", 32'(rx_data), 32'h22);
    checkOutput("t3b_overrun_kept", 32'(overrun), 32'd1);
    pulse_ack();
    pulse_clr();
    checkOutput("t3_overrun_clr", 32'(overrun), 32'd0);

    // 4: second byte loaded during the frame goes out at the boundary
    pulse_load(8'h81);
    miso_q.push_back(8'h81);
    miso_q.push_back(8'h7E);
    rx_q.push_back(8'h12);
    rx_q.push_back(8'h34);
    frame_begin();
    checkOutput("t4_tx_ready_first", 32'(tx_ready), 32'd1);
    pulse_load(8'h7E);
    checkOutput("t4_tx_ready_reload", 32'(tx_ready), 32'd0);
    xfer(8'h12, "t4_b0");
    wait_clks(4);
    checkOutput("t4_tx_ready_second", 32'(tx_ready), 32'd1);
    pulse_ack();
    xfer(8'h34, "t4_b1");
    frame_end();
    checkOutput("t4_rx_data", 32'(rx_data), 32'h34);
    checkOutput("t4_underrun_trailing", 32'(underrun), 32'd1);
    pulse_ack();
    pulse_clr();

    // 5: frame aborted after 5 bits leaves no byte behind
    frame_begin();
    applyStimulus(8'hA0, 5, got);
    cs_n = 1'b1;
    wait_clks(6);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("t5_overrun", 32'(overrun), 32'd0);
    pulse_clr();
    rx_q.push_back(8'hC3);
    miso_q.push_back(8'hFF);
    frame_begin();
    xfer(8'hC3, "t5");
    frame_end();
    checkOutput("t5_rx_data", 32'(rx_data), 32'hC3);
    pulse_ack();
    pulse_clr();

    // 6: reset in the middle of a frame
    pulse_load(8'h33);
    frame_begin();
    applyStimulus(8'hFF, 3, got);
    rst = 1'b1;
    wait_clks(2);
    checkResetValues("t6_rst");
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(2);
    checkOutput("t6_busy_after", 32'(busy), 32'd0);
    pulse_load(8'h96);
    miso_q.push_back(8'h96);
    rx_q.push_back(8'h5A);
    frame_begin();
    xfer(8'h5A, "t6");
    frame_end();
    checkOutput("t6_rx_data", 32'(rx_data), 32'h5A);
    checkOutput("t6_rx_valid", 32'(rx_valid), 32'd1);
    pulse_ack();

    wait_clks(2);
    checkOutput("rx_q_drained", 32'(rx_q.size()), 32'd0);
    checkOutput("miso_q_drained", 32'(miso_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
